// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared state and requester encodings for the ROM arbiter.
package rom_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef enum logic {
      REQ_IFU = 1'b0,
      REQ_LSU = 1'b1
   } req_t;

endpackage

// File: rtl/rom_arb.sv
// rom_arb: round-robin IFU/LSU arbiter and sequencer for a single-port synchronous ROM.
module rom_arb
   import rom_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ROM_AW     = 10
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst,
   input  logic                  i_ifu_req_valid,
   output logic                  o_ifu_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_ifu_req_addr,
   output logic                  o_ifu_resp_valid,
   input  logic                  i_ifu_resp_ready,
   output logic [DATA_WIDTH-1:0] o_ifu_resp_data,
   output logic                  o_ifu_resp_err,
   input  logic                  i_lsu_req_valid,
   output logic                  o_lsu_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_lsu_req_addr,
   output logic                  o_lsu_resp_valid,
   input  logic                  i_lsu_resp_ready,
   output logic [DATA_WIDTH-1:0] o_lsu_resp_data,
   output logic                  o_lsu_resp_err,
   output logic                  o_rom_en,
   output logic [ROM_AW-1:0]     o_rom_addr,
   input  logic [DATA_WIDTH-1:0] i_rom_data
);

   state_t                state_q, state_d;
   req_t                  last_q, last_d;
   req_t                  id_q, id_d;
   logic [ROM_AW-1:0]     idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  err_q, err_d;

   logic                  gnt_ifu, gnt_lsu, req_hs, resp_hs;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  unused_addr;

   // On a tie the requester that did not win last time gets the slot
   assign gnt_ifu  = i_ifu_req_valid && (!i_lsu_req_valid || last_q == REQ_LSU);
   assign gnt_lsu  = i_lsu_req_valid && !gnt_ifu;
   assign req_hs   = state_q == IDLE && (gnt_ifu || gnt_lsu);
   assign sel_addr = gnt_lsu ? i_lsu_req_addr : i_ifu_req_addr;
   assign resp_hs  = state_q == RESP && (id_q == REQ_IFU ? i_ifu_resp_ready : i_lsu_resp_ready);

   assign unused_addr = ^{i_ifu_req_addr, i_lsu_req_addr};

   assign o_ifu_req_ready  = state_q == IDLE && gnt_ifu;
   assign o_lsu_req_ready  = state_q == IDLE && gnt_lsu;
   assign o_ifu_resp_valid = state_q == RESP && id_q == REQ_IFU;
   assign o_lsu_resp_valid = state_q == RESP && id_q == REQ_LSU;
   assign o_ifu_resp_data  = data_q;
   assign o_lsu_resp_data  = data_q;
   assign o_ifu_resp_err   = err_q;
   assign o_lsu_resp_err   = err_q;
   assign o_rom_en         = state_q == ACCESS;
   assign o_rom_addr       = idx_q;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      idx_d   = idx_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (req_hs) begin
            id_d    = gnt_lsu ? REQ_LSU : REQ_IFU;
            last_d  = gnt_lsu ? REQ_LSU : REQ_IFU;
            idx_d   = sel_addr[ROM_AW+1:2];
            err_d   = |sel_addr[1:0];
            data_d  = '0;
            state_d = (|sel_addr[1:0]) ? RESP : ACCESS;
         end
         ACCESS: state_d = WAIT;
         WAIT: begin
            data_d  = i_rom_data;
            err_d   = 1'b0;
            state_d = RESP;
         end
         RESP: state_d = resp_hs ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state_q <= IDLE;
         last_q  <= REQ_LSU;
         id_q    <= REQ_IFU;
         idx_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_rom_arb.sv
// tb_rom_arb: directed stimulus with a response scoreboard for rom_arb.
module tb_rom_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
   logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
   logic [31:0] ifu_req_addr, lsu_req_addr, ifu_resp_data, lsu_resp_data;
   logic        rom_en;
   logic [9:0]  rom_addr;
   logic [31:0] rom_data;
   logic [31:0] rom [1024];
   int          checks = 0;
   int          errors = 0;
   int          en_count = 0;

   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;

   exp_t ifu_q[$];
   exp_t lsu_q[$];
   exp_t mi, ml;

   always #5 clk = ~clk;

   rom_arb dut (
      .i_sys_clk       (clk),
      .i_sys_rst       (rst),
      .i_ifu_req_valid (ifu_req_valid),
      .o_ifu_req_ready (ifu_req_ready),
      .i_ifu_req_addr  (ifu_req_addr),
      .o_ifu_resp_valid(ifu_resp_valid),
      .i_ifu_resp_ready(ifu_resp_ready),
      .o_ifu_resp_data (ifu_resp_data),
      .o_ifu_resp_err  (ifu_resp_err),
      .i_lsu_req_valid (lsu_req_valid),
      .o_lsu_req_ready (lsu_req_ready),
      .i_lsu_req_addr  (lsu_req_addr),
      .o_lsu_resp_valid(lsu_resp_valid),
      .i_lsu_resp_ready(lsu_resp_ready),
      .o_lsu_resp_data (lsu_resp_data),
      .o_lsu_resp_err  (lsu_resp_err),
      .o_rom_en        (rom_en),
      .o_rom_addr      (rom_addr),
      .i_rom_data      (rom_data)
   );

   always @(posedge clk) begin
      if (rom_en) begin
         rom_data <= rom[rom_addr];
         en_count <= en_count + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (ifu_resp_valid && ifu_resp_ready) begin
            if (ifu_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ifu_unexpected_resp: got data %0h required no response", ifu_resp_data);
            end else begin
               mi = ifu_q.pop_front();
               chk("ifu_resp_data", 64'(ifu_resp_data), 64'(mi.d));
               chk("ifu_resp_err", 64'(ifu_resp_err), 64'(mi.e));
            end
         end
         if (lsu_resp_valid && lsu_resp_ready) begin
            if (lsu_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL lsu_unexpected_resp: got data %0h required no response", lsu_resp_data);
            end else begin
               ml = lsu_q.pop_front();
               chk("lsu_resp_data", 64'(lsu_resp_data), 64'(ml.d));
               chk("lsu_resp_err", 64'(lsu_resp_err), 64'(ml.e));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output int who);
      who = -1;
      for (int i = 0; i < 20 && who < 0; i++) begin
         @(negedge clk);
         if (ifu_req_ready) who = 0;
         else if (lsu_req_ready) who = 1;
      end
      if (who < 0) chk("grant_timeout", 64'd1, 64'd0);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_ctrl"}, 64'({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                                ifu_resp_err, lsu_resp_err, rom_en, rom_addr}), 64'd0);
      chk({name, "_data"}, {ifu_resp_data, lsu_resp_data}, 64'd0);
   endtask

   initial begin
      int who, n, c0;
      logic seen;
      for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 + i * 32'h111;
      rom[1] = 32'hDEAD_BEEF;
      rst = 1'b1;
      ifu_req_valid = 0; ifu_req_addr = 0; ifu_resp_ready = 1;
      lsu_req_valid = 0; lsu_req_addr = 0; lsu_resp_ready = 1;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      tick();
      rst = 1'b0;
      tick();

      // single aligned IFU read with cycle-exact timing
      ifu_q.push_back('{32'hDEAD_BEEF, 1'b0});
      ifu_req_valid = 1; ifu_req_addr = 32'h4;
      wait_grant(who);
      chk("single_grant", 64'(who), 64'd0);
      tick();
      ifu_req_valid = 0;
      @(negedge clk);
      chk("single_rom_en", 64'({rom_en, rom_addr}), 64'({1'b1, 10'd1}));
      chk("single_ready_low", 64'(ifu_req_ready), 64'd0);
      @(negedge clk);
      chk("single_t2_no_resp", 64'(ifu_resp_valid), 64'd0);
      @(negedge clk);
      chk("single_t3_resp", 64'(ifu_resp_valid), 64'd1);
      tick();

      // reset mid-access: IFU was the last winner, so a restored r_last lets IFU win the next tie
      ifu_req_valid = 1; ifu_req_addr = 32'h8;
      wait_grant(who);
      tick();
      ifu_req_valid = 0;
      rst = 1'b1;
      #1;
      chk_zero("midrst");
      tick();
      tick();
      rst = 1'b0;

      // both held valid: grants alternate starting with IFU
      repeat (2) ifu_q.push_back('{32'h1000_0000, 1'b0});
      repeat (2) lsu_q.push_back('{32'h1000_0222, 1'b0});
      ifu_req_valid = 1; ifu_req_addr = 32'h0;
      lsu_req_valid = 1; lsu_req_addr = 32'h8;
      for (int k = 0; k < 4; k++) begin
         wait_grant(who);
         chk("alt_grant", 64'(who), 64'(k % 2));
         chk("alt_one_ready", 64'(ifu_req_ready + lsu_req_ready), 64'd1);
         tick();
      end
      ifu_req_valid = 0; lsu_req_valid = 0;
      repeat (5) tick();

      // LSU backpressure with a pending IFU request
      lsu_q.push_back('{32'h1000_0333, 1'b0});
      lsu_resp_ready = 0;
      lsu_req_valid = 1; lsu_req_addr = 32'hC;
      wait_grant(who);
      chk("bp_grant", 64'(who), 64'd1);
      tick();
      lsu_req_valid = 0;
      ifu_req_valid = 1; ifu_req_addr = 32'h0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = lsu_resp_valid;
      end
      chk("bp_resp_seen", 64'(seen), 64'd1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("bp_hold", {lsu_resp_valid, lsu_resp_err, ifu_req_ready, lsu_req_ready, rom_en,
                         27'd0, lsu_resp_data}, {5'b10000, 27'd0, 32'h1000_0333});
         tick();
      end
      lsu_resp_ready = 1;
      ifu_req_valid = 0;
      repeat (3) tick();

      // misaligned LSU read: error response the next cycle, ROM never enabled
      lsu_q.push_back('{32'h0, 1'b1});
      c0 = en_count;
      lsu_req_valid = 1; lsu_req_addr = 32'h6;
      wait_grant(who);
      chk("mis_grant", 64'(who), 64'd1);
      tick();
      lsu_req_valid = 0;
      @(negedge clk);
      chk("mis_t1_resp", 64'({lsu_resp_valid, lsu_resp_err, rom_en}), 64'b110);
      repeat (3) @(negedge clk);
      chk("mis_no_rom_en", 64'(en_count), 64'(c0));

      // reset while in WAIT drops the IFU read
      tick();
      ifu_req_valid = 1; ifu_req_addr = 32'h10;
      wait_grant(who);
      tick();
      ifu_req_valid = 0;
      tick();
      rst = 1'b1;
      #1;
      chk_zero("waitrst");
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seen = seen | ifu_resp_valid;
      end
      chk("waitrst_no_resp", 64'(seen), 64'd0);
      tick();
      ifu_q.push_back('{32'h1000_0555, 1'b0});
      ifu_req_valid = 1; ifu_req_addr = 32'h14;
      wait_grant(who);
      tick();
      ifu_req_valid = 0;
      n = 0;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         n++;
         seen = ifu_resp_valid;
      end
      chk("recover_latency", 64'(n), 64'd3);
      tick();

      // upper address bits ignored: 0x1008 maps to word 2
      lsu_q.push_back('{32'h1000_0222, 1'b0});
      lsu_req_valid = 1; lsu_req_addr = 32'h1008;
      wait_grant(who);
      tick();
      lsu_req_valid = 0;
      @(negedge clk);
      chk("wrap_rom_addr", 64'({rom_en, rom_addr}), 64'({1'b1, 10'd2}));
      repeat (6) tick();

      chk("ifu_q_drained", 64'(ifu_q.size()), 64'd0);
      chk("lsu_q_drained", 64'(lsu_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
